// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and status flags shared by seq_alu.
// SEQ_ALU_ROTATE_EN extends the legal opcode range with rol/ror.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ROL = 4'd10,
    OP_ROR = 4'd11
  } alu_op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
    logic err;
  } alu_flags_t;

`ifdef SEQ_ALU_ROTATE_EN
  localparam alu_op_e ALU_OP_LAST = OP_ROR;
`else
  localparam alu_op_e ALU_OP_LAST = OP_SHR;
`endif

  function automatic logic op_is_iter(alu_op_e o);
    return (o == OP_MUL) || (o == OP_DIV) || (o == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: shift-add multiplier and restoring divider, one bit per cycle.
// hi/lo present the post-step value so the caller can capture on last.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         last
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  acc, q, bb;
  logic [N-1:0]  n_acc, n_q;
  logic [N:0]    sum, rem, diff;
  logic [CW-1:0] cnt;
  logic          div_q, run;

  assign sum  = {1'b0, acc} + (q[0] ? {1'b0, bb} : '0);
  assign rem  = {acc, q[N-1]};
  assign diff = rem - {1'b0, bb};

  always_comb begin
    n_acc = acc;
    n_q   = q;
    if (div_q) begin
      // a clear sign bit means the trial subtraction fits
      if (!diff[N]) begin
        n_acc = diff[N-1:0];
        n_q   = {q[N-2:0], 1'b1};
      end else begin
        n_acc = rem[N-1:0];
        n_q   = {q[N-2:0], 1'b0};
      end
    end else begin
      n_acc = sum[N:1];
      n_q   = {sum[0], q[N-1:1]};
    end
  end

  assign hi   = n_acc;
  assign lo   = n_q;
  assign last = run && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      q     <= '0;
      bb    <= '0;
      div_q <= 1'b0;
      run   <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      q     <= a;
      bb    <= b;
      div_q <= is_div;
      run   <= 1'b1;
      cnt   <= CW'(N - 1);
    end else if (run) begin
      acc <= n_acc;
      q   <= n_q;
      cnt <= cnt - CW'(1);
      if (cnt == '0) run <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU, single-cycle arith/logic plus iterative mul/div/mod.
// Define SEQ_ALU_ROTATE_EN to enable the rol/ror opcodes.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         negative,
  output logic         overflow,
  output logic         err
);

  alu_state_e   state;
  alu_op_e      op_e, op_q;
  alu_flags_t   fl_q, n_fl;
  logic         bz_q, iter, upd, load, is_div, md_last;
  logic         s_c, s_v, s_e;
  logic [N-1:0] md_hi, md_lo, s_res, n_res, n_hi;
  logic [N:0]   add_w, sub_w, shl_w, shr_w;

  assign op_e   = alu_op_e'(op);
  assign iter   = op_is_iter(op_e);
  assign load   = (state == IDLE) && start && iter;
  assign is_div = (op_e == OP_DIV) || (op_e == OP_MOD);

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign shl_w = {1'b0, a} << b;
  assign shr_w = {a, 1'b0} >> b;

`ifdef SEQ_ALU_ROTATE_EN
  logic [N-1:0] rot_amt, rol_w, ror_w;
  assign rot_amt = b % N'(N);
  assign rol_w   = (a << rot_amt) | (a >> (N'(N) - rot_amt));
  assign ror_w   = (a >> rot_amt) | (a << (N'(N) - rot_amt));
`endif

  seq_muldiv #(.N(N)) u_md (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .is_div(is_div),
    .a     (a),
    .b     (b),
    .hi    (md_hi),
    .lo    (md_lo),
    .last  (md_last)
  );

  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_e   = 1'b0;
    unique case (op_e)
      OP_ADD: begin
        s_res = add_w[N-1:0];
        s_c   = add_w[N];
        s_v   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
      end
      OP_SUB: begin
        s_res = sub_w[N-1:0];
        s_c   = sub_w[N];
        s_v   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
      end
      OP_MUL, OP_DIV, OP_MOD: begin
        s_res = '0;
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_SHL: begin
        s_res = shl_w[N-1:0];
        s_c   = shl_w[N];
      end
      OP_SHR: begin
        s_res = shr_w[N:1];
        s_c   = shr_w[0];
      end
`ifdef SEQ_ALU_ROTATE_EN
      OP_ROL: begin
        s_res = rol_w;
        s_c   = (rot_amt != '0) && rol_w[0];
      end
      OP_ROR: begin
        s_res = ror_w;
        s_c   = (rot_amt != '0) && ror_w[N-1];
      end
`endif
      default: s_e = 1'b1;
    endcase
  end

  always_comb begin
    upd   = 1'b0;
    n_res = '0;
    n_hi  = '0;
    n_fl  = '0;
    if ((state == IDLE) && start && !iter) begin
      upd           = 1'b1;
      n_res         = s_res;
      n_fl.carry    = s_c;
      n_fl.overflow = s_v;
      n_fl.err      = s_e;
      n_fl.zero     = !s_e && (s_res == '0);
      n_fl.negative = s_res[N-1];
    end else if ((state == CALC) && md_last) begin
      upd = 1'b1;
      if (op_q == OP_MUL) begin
        n_res         = md_lo;
        n_hi          = md_hi;
        n_fl.overflow = (md_hi != '0);
        n_fl.zero     = ({md_hi, md_lo} == '0);
      end else begin
        // divide by zero: the divider remainder already equals a
        if (bz_q) begin
          n_res         = '1;
          n_hi          = md_hi;
          n_fl.err      = 1'b1;
          n_fl.overflow = 1'b1;
        end else if (op_q == OP_DIV) begin
          n_res = md_lo;
          n_hi  = md_hi;
        end else begin
          n_res = md_hi;
          n_hi  = md_lo;
        end
        n_fl.zero = (n_res == '0);
      end
      n_fl.negative = n_res[N-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_q      <= OP_ADD;
      bz_q      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      fl_q      <= '0;
    end else begin
      done <= upd;
      if (upd) begin
        result    <= n_res;
        result_hi <= n_hi;
        fl_q      <= n_fl;
      end
      unique case (state)
        IDLE: begin
          if (start && iter) begin
            state <= CALC;
            busy  <= 1'b1;
            op_q  <= op_e;
            bz_q  <= (b == '0);
          end
        end
        CALC: begin
          if (md_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign carry    = fl_q.carry;
  assign zero     = fl_q.zero;
  assign negative = fl_q.negative;
  assign overflow = fl_q.overflow;
  assign err      = fl_q.err;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: N=4 and N=8 instances checked every cycle against a
// behavioural model, plus directed literal checks.
module tb_seq_alu;

  typedef struct {
    int res;
    int hi;
    bit c;
    bit z;
    bit n;
    bit v;
    bit e;
    bit it;
  } rec_t;

`ifdef SEQ_ALU_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] st;
  logic [3:0] opv [2];
  logic [7:0] av [2];
  logic [7:0] bv [2];

  logic       busy4, done4, c4, z4, n4, v4, e4;
  logic       busy8, done8, c8, z8, n8, v8, e8;
  logic [3:0] r4, h4;
  logic [7:0] r8, h8;

  int errors = 0;
  int checks = 0;

  int   cyc  [2];
  bit   pv   [2];
  int   due  [2];
  rec_t prec [2];
  rec_t cur  [2];
  bit   dexp [2];

  seq_alu #(.N(4)) u4 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .op(opv[0]),
    .a(av[0][3:0]), .b(bv[0][3:0]), .busy(busy4), .done(done4),
    .result(r4), .result_hi(h4), .carry(c4), .zero(z4),
    .negative(n4), .overflow(v4), .err(e4)
  );

  seq_alu #(.N(8)) u8 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .op(opv[1]),
    .a(av[1]), .b(bv[1]), .busy(busy8), .done(done8),
    .result(r8), .result_hi(h8), .carry(c8), .zero(z8),
    .negative(n8), .overflow(v8), .err(e8)
  );

  always #5 clk = ~clk;

  function automatic int wid(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int sg(input int x, input int w);
    return (x >> (w - 1)) & 1;
  endfunction

  function automatic rec_t model(input int w, input int op,
                                 input int a, input int b);
    rec_t r;
    int m, s;
    m = (1 << w) - 1;
    r = '{default: 0};
    case (op)
      0: begin
        r.res = (a + b) & m;
        r.c   = (a + b) > m;
        r.v   = (sg(a, w) == sg(b, w)) && (sg(r.res, w) != sg(a, w));
      end
      1: begin
        r.res = (a - b) & m;
        r.c   = a < b;
        r.v   = (sg(a, w) != sg(b, w)) && (sg(r.res, w) != sg(a, w));
      end
      2: begin
        r.it  = 1;
        r.res = (a * b) & m;
        r.hi  = (a * b) >> w;
        r.v   = r.hi != 0;
      end
      3, 4: begin
        r.it = 1;
        if (b == 0) begin
          r.res = m;
          r.hi  = a;
          r.e   = 1;
          r.v   = 1;
        end else if (op == 3) begin
          r.res = a / b;
          r.hi  = a % b;
        end else begin
          r.res = a % b;
          r.hi  = a / b;
        end
      end
      5: r.res = a & b;
      6: r.res = a | b;
      7: r.res = a ^ b;
      8: begin
        if (b < w) r.res = (a << b) & m;
        if (b >= 1 && b <= w) r.c = ((a >> (w - b)) & 1) != 0;
      end
      9: begin
        if (b < w) r.res = a >> b;
        if (b >= 1 && b <= w) r.c = ((a >> (b - 1)) & 1) != 0;
      end
      10, 11: begin
        if (!ROT_EN) begin
          r.e = 1;
        end else begin
          s = b % w;
          if (op == 10) begin
            r.res = ((a << s) | (a >> (w - s))) & m;
            if (s != 0) r.c = ((a >> (w - s)) & 1) != 0;
          end else begin
            r.res = ((a >> s) | (a << (w - s))) & m;
            if (s != 0) r.c = ((a >> (s - 1)) & 1) != 0;
          end
        end
      end
      default: r.e = 1;
    endcase
    if (op == 2) r.z = (r.res == 0) && (r.hi == 0);
    else r.z = (r.res == 0);
    if (r.e && op != 3 && op != 4) r.z = 0;
    r.n = sg(r.res, w) != 0;
    return r;
  endfunction

  task automatic clear_model(input int i);
    pv[i]   = 0;
    dexp[i] = 0;
    due[i]  = 0;
    cur[i]  = '{default: 0};
    prec[i] = '{default: 0};
  endtask

  task automatic model_edge(input int i);
    bit   acc;
    rec_t r;
    int   m;
    m = (1 << wid(i)) - 1;
    cyc[i]++;
    dexp[i] = 0;
    acc = st[i] && !pv[i];
    if (pv[i] && cyc[i] == due[i]) begin
      cur[i]  = prec[i];
      pv[i]   = 0;
      dexp[i] = 1;
    end
    if (acc) begin
      r = model(wid(i), int'(opv[i]), int'(av[i]) & m, int'(bv[i]) & m);
      if (r.it) begin
        pv[i]   = 1;
        prec[i] = r;
        due[i]  = cyc[i] + wid(i);
      end else begin
        cur[i]  = r;
        dexp[i] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) if (!rst[i]) model_edge(i);
  end

  task automatic cmp(input int i, input logic bz, input logic dn,
                     input logic [7:0] r, input logic [7:0] h,
                     input logic c, input logic z, input logic n,
                     input logic v, input logic e);
    rec_t x;
    x = cur[i];
    checks++;
    if (bz !== logic'(pv[i]) || dn !== logic'(dexp[i]) ||
        r !== 8'(x.res) || h !== 8'(x.hi) ||
        {c, z, n, v, e} !== {x.c, x.z, x.n, x.v, x.e}) begin
      errors++;
      $display("FAIL cycle_n%0d t=%0t got busy=%b done=%b res=%h hi=%h czvne=%b%b%b%b%b need busy=%b done=%b res=%h hi=%h czvne=%b%b%b%b%b",
               wid(i), $time, bz, dn, r, h, c, z, v, n, e,
               pv[i], dexp[i], 8'(x.res), 8'(x.hi), x.c, x.z, x.v, x.n, x.e);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, busy4, done4, {4'h0, r4}, {4'h0, h4}, c4, z4, n4, v4, e4);
    cmp(1, busy8, done8, r8, h8, c8, z8, n8, v8, e8);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d need=%0d", nm, got, exp);
    end
  endtask

  task automatic go(input int i, input int o, input int x, input int y);
    st[i]  = 1'b1;
    opv[i] = 4'(o);
    av[i]  = 8'(x);
    bv[i]  = 8'(y);
    @(posedge clk); #1;
    st[i]  = 1'b0;
    opv[i] = 4'($urandom);
    av[i]  = 8'($urandom);
    bv[i]  = 8'($urandom);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (((i == 0) ? busy4 : busy8) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_n%0d got=busy need=idle", wid(i));
    end
  endtask

  task automatic rnd(input int i, input int n);
    int w, m;
    w = wid(i);
    m = (1 << w) - 1;
    for (int t = 0; t < n; t++) begin
      st[i]  = ($urandom % 3) == 0;
      opv[i] = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 12);
      av[i]  = 8'($urandom & m);
      if ($urandom % 6 == 0) bv[i] = 8'h00;
      else if ($urandom % 4 == 0) bv[i] = 8'($urandom % (w + 2));
      else bv[i] = 8'($urandom & m);
      if ($urandom % 200 == 0) begin
        st[i]  = 1'b0;
        rst[i] = 1'b1;
        clear_model(i);
      end
      @(posedge clk); #1;
      rst[i] = 1'b0;
    end
    st[i] = 1'b0;
  endtask

  task automatic seq4();
    int nb, nd;
    go(0, 0, 9, 7);
    @(negedge clk);
    chk("add_done", done4, 1);
    chk("add_res", r4, 0);
    chk("add_carry", c4, 1);
    chk("add_zero", z4, 1);
    chk("add_ovf", v4, 0);
    @(posedge clk); #1;
    go(0, 1, 3, 5);
    @(negedge clk);
    chk("sub_res", r4, 14);
    chk("sub_borrow", c4, 1);
    chk("sub_neg", n4, 1);
    chk("sub_ovf", v4, 0);
    @(posedge clk); #1;
    go(0, 2, 7, 9);
    nb = 0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      nb += int'(busy4);
      nd += int'(done4);
    end
    chk("mul_busy_cycles", nb, 4);
    chk("mul_done_pulses", nd, 1);
    chk("mul_res", r4, 15);
    chk("mul_hi", h4, 3);
    chk("mul_ovf", v4, 1);
    @(posedge clk); #1;
    go(0, 3, 13, 4);
    wait_idle(0);
    @(negedge clk);
    chk("div_done", done4, 1);
    chk("div_res", r4, 3);
    chk("div_hi", h4, 1);
    @(posedge clk); #1;
    go(0, 3, 6, 0);
    wait_idle(0);
    @(negedge clk);
    chk("div0_res", r4, 15);
    chk("div0_hi", h4, 6);
    chk("div0_err", e4, 1);
    @(posedge clk); #1;
    go(0, 2, 15, 15);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    clear_model(0);
    @(negedge clk);
    chk("abort_res", {r4, h4}, 0);
    chk("abort_flags", {busy4, done4, c4, z4, n4, v4, e4}, 0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      nd += int'(done4);
    end
    chk("abort_no_done", nd, 0);
    @(posedge clk); #1;
    go(0, 0, 1, 1);
    @(negedge clk);
    chk("after_abort_add", r4, 2);
    @(posedge clk); #1;
    rnd(0, 400);
  endtask

  task automatic seq8();
    int nd;
    go(1, 3, 200, 7);
    st[1] = 1'b1;
    nd = 0;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      nd += int'(done8);
      @(posedge clk); #1;
      if (t == 7) begin
        opv[1] = 4'd10;
        av[1]  = 8'h81;
        bv[1]  = 8'd3;
      end else if (t == 8) begin
        st[1] = 1'b0;
      end else begin
        st[1]  = ($urandom % 2) == 0;
        opv[1] = 4'($urandom);
        av[1]  = 8'($urandom);
        bv[1]  = 8'($urandom);
      end
    end
    repeat (3) begin
      @(negedge clk);
      nd += int'(done8);
    end
    chk("b2b_done_pulses", nd, 2);
    chk("rot_err", e8, int'(!ROT_EN));
    chk("rot_res", r8, ROT_EN ? 12 : 0);
    @(posedge clk); #1;
    rnd(1, 400);
  endtask

  initial begin
    rec_t p;
    rst = 2'b11;
    st  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      opv[i] = '0;
      av[i]  = '0;
      bv[i]  = '0;
      cyc[i] = 0;
      clear_model(i);
    end
    p = model(4, 0, 9, 7);
    chk("pin_add", {p.res, p.c, p.z, p.v}, 32'h0000_0006 | 32'h0);
    p = model(4, 2, 7, 9);
    chk("pin_mul", p.res * 16 + p.hi, 15 * 16 + 3);
    p = model(8, 9, 8'h81, 8);
    chk("pin_shr8", p.res * 2 + int'(p.c), 1);
    p = model(4, 13, 5, 5);
    chk("pin_illegal", {p.res, p.z, p.e}, 1);
    @(negedge clk);
    chk("rst_n4", {busy4, done4, r4, h4, c4, z4, n4, v4, e4}, 0);
    chk("rst_n8", {busy8, done8, r8, h8, c8, z8, n8, v8, e8}, 0);
    @(posedge clk); #1;
    rst = 2'b00;
    fork
      seq4();
      seq8();
    join
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running need=finished");
    $fatal(1, "timeout");
  end

endmodule
